fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: default widths and the request FSM states.
package fetch_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned DEPTH_DEF = 4;

    // READY: nothing outstanding, WAIT: one request in flight, DISCARD: in-flight response is stale.
    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of PC, instruction-memory and decode handshake signals around the fetch queue.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);

    logic [XLEN-1:0] pc_i;
    logic            pc_hold_o;
    logic            flush_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            decode_ready_i;

    // The fetch queue is the master of the memory request and of the decode stream.
    modport master (
        input  pc_i, flush_i, imem_rvalid_i, imem_rdata_i, decode_ready_i,
        output pc_hold_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

    modport slave (
        output pc_i, flush_i, imem_rvalid_i, imem_rdata_i, decode_ready_i,
        input  pc_hold_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs, with a single-cycle clear.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = 2 * XLEN_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; readers only trust it while count_o != 0.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory request, flush handling, and a decode buffer.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned XLEN  = XLEN_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_queue_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pend_pc_q;

    logic            issue;
    logic            hold;
    logic            latch_pc;
    logic            push;
    logic            pop;
    logic            clear;
    logic            instr_valid;
    logic [CW-1:0]   count;
    logic [2*XLEN-1:0] head;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_READY;
            pend_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_pc) pend_pc_q <= bus.pc_i;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d  = state_q;
        issue    = 1'b0;
        hold     = 1'b1;
        latch_pc = 1'b0;
        push     = 1'b0;
        clear    = 1'b0;

        if (rst_i) begin
            hold = 1'b0;
        end else if (bus.flush_i) begin
            hold  = 1'b0;
            clear = 1'b1;
            // A response still in flight belongs to the old path and must be swallowed.
            unique case (state_q)
                ST_WAIT, ST_DISCARD: state_d = bus.imem_rvalid_i ? ST_READY : ST_DISCARD;
                default:             state_d = ST_READY;
            endcase
        end else begin
            unique case (state_q)
                ST_READY: begin
                    if (count < FULL_CNT) begin
                        issue    = 1'b1;
                        hold     = 1'b0;
                        latch_pc = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        push    = 1'b1;
                        state_d = ST_READY;
                    end
                end
                ST_DISCARD: begin
                    if (bus.imem_rvalid_i) state_d = ST_READY;
                end
                default: state_d = ST_READY;
            endcase
        end
    end

    assign instr_valid = !rst_i && !bus.flush_i && (count != '0);
    assign pop         = instr_valid && bus.decode_ready_i;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .wdata_i ({pend_pc_q, bus.imem_rdata_i}),
        .rdata_o (head),
        .count_o (count)
    );

    assign bus.imem_req_o    = issue;
    assign bus.imem_addr_o   = bus.pc_i;
    assign bus.pc_hold_o     = hold;
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_pc_o    = head[2*XLEN-1:XLEN];
    assign bus.instr_o       = head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue against a transaction-level buffer model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int NCYC = 1500;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    entry_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int pops   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Monitor: compares the head of the decode stream with the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                check("instr_valid", 64'(bus.instr_valid_o),
                      64'((exp_q.size() != 0) && !bus.flush_i));
                if (bus.instr_valid_o && exp_q.size() != 0) begin
                    check("instr_pc", 64'(bus.instr_pc_o), 64'(exp_q[0].pc));
                    check("instr", 64'(bus.instr_o), 64'(exp_q[0].instr));
                    if (bus.decode_ready_i) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    // Stimulus, memory responder and buffer-occupancy model.
    initial begin
        logic [XLEN-1:0] pc_cur, pc_next, tgt, req_pc, rsp_addr;
        bit outstanding, discard, stale_next;
        bit rst_now, flush_now, rvalid_now, exp_req, exp_hold;
        int countdown, cnt_now, p_ready, p_flush, p_rst, max_lat;

        rst = 1'b1;
        bus.pc_i = '0;
        bus.flush_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        bus.decode_ready_i = 1'b0;
        pc_cur = '0;
        req_pc = '0;
        rsp_addr = '0;
        outstanding = 0;
        discard = 0;
        stale_next = 0;
        countdown = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if (cyc < 40) begin
                p_ready = 100; p_flush = 0; p_rst = 0; max_lat = 1;
            end else if (cyc < 80) begin
                p_ready = (cyc == 75) ? 100 : 0; p_flush = 0; p_rst = 0; max_lat = 2;
            end else if (cyc < 600) begin
                p_ready = 70; p_flush = 8; p_rst = 0; max_lat = 4;
            end else if (cyc < 1200) begin
                p_ready = 60; p_flush = 6; p_rst = 3; max_lat = 4;
            end else begin
                p_ready = 95; p_flush = 15; p_rst = 0; max_lat = 2;
            end

            rst_now   = (cyc < 2) || ($urandom_range(0, 99) < p_rst);
            flush_now = (cyc == 40) || ($urandom_range(0, 99) < p_flush);
            if (cyc == 40) tgt = 32'h100;

            rvalid_now = 0;
            if (stale_next) begin
                rvalid_now = 1;
                stale_next = 0;
                bus.imem_rdata_i = 32'hDEAD_BEEF;
            end else if (outstanding && countdown == 0) begin
                rvalid_now = 1;
                bus.imem_rdata_i = mem_word(rsp_addr);
            end else if (outstanding) begin
                countdown--;
            end else if ($urandom_range(0, 99) < 5) begin
                rvalid_now = 1;
                bus.imem_rdata_i = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
            end

            rst = rst_now;
            bus.pc_i = pc_cur;
            bus.flush_i = flush_now;
            bus.imem_rvalid_i = rvalid_now;
            bus.decode_ready_i = ($urandom_range(0, 99) < p_ready);
            cnt_now = exp_q.size();

            #2;
            if (rst_now) begin
                check("rst_req", 64'(bus.imem_req_o), 64'(0));
                check("rst_hold", 64'(bus.pc_hold_o), 64'(0));
                check("rst_valid", 64'(bus.instr_valid_o), 64'(0));
                exp_q.delete();
                stale_next = outstanding;
                outstanding = 0;
                discard = 0;
                pc_next = '0;
            end else begin
                exp_req  = !flush_now && !outstanding && (cnt_now < DEPTH);
                exp_hold = !flush_now && (outstanding || cnt_now == DEPTH);
                check("imem_req", 64'(bus.imem_req_o), 64'(exp_req));
                check("pc_hold", 64'(bus.pc_hold_o), 64'(exp_hold));
                if (exp_req && bus.imem_req_o)
                    check("imem_addr", 64'(bus.imem_addr_o), 64'(pc_cur));

                if (rvalid_now && outstanding) begin
                    if (!flush_now && !discard)
                        exp_q.push_back('{pc: req_pc, instr: mem_word(req_pc)});
                    outstanding = 0;
                    discard = 0;
                end else if (flush_now && outstanding) begin
                    discard = 1;
                end
                if (flush_now) exp_q.delete();

                if (bus.imem_req_o) begin
                    outstanding = 1;
                    discard = 0;
                    req_pc = pc_cur;
                    rsp_addr = bus.imem_addr_o;
                    countdown = $urandom_range(1, max_lat) - 1;
                end
                pc_next = flush_now ? tgt : (exp_hold ? pc_cur : pc_cur + 32'd4);
            end
            pc_cur = pc_next;
        end

        @(negedge clk);
        #3;
        check("pops_seen", 64'(pops > 150), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
